regfile_write_port: RTL
=======================

# regfile_write_port

Write side of the 32 x 32-bit register file. Accepts register write-back requests through a valid/ready handshake, buffers them in a 2-entry in-order queue, and commits at most one per cycle into 32 architectural registers. Exposes all registers as a flattened bus that feeds the 32:1 read multiplexers. Register 0 is hardwired to zero.

## Interface
Parameters:
- DEPTH, 2, write-queue entries (fixed at 2; other values unsupported)

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- wr_valid  input  1  write request present
- wr_ready  output  1  queue can accept a request this cycle
- wr_addr  input  5  destination register
- wr_data  input  32  write data
- commit_en  input  1  permit head-of-queue commit this cycle
- regs_flat  output  1024  register r at bits [32r+31:32r]
- q_addr  input  5  hazard query address
- q_pending  output  1  a queued, uncommitted write targets q_addr
- q_fwd_data  output  32  data of the youngest queued write to q_addr
- q_count  output  2  current queue occupancy (0..2)

## Operation
- Accept: a request is accepted on a rising edge with wr_valid && wr_ready. wr_ready = (q_count < 2) || (commit_en && q_count != 0).
- Accept with wr_addr == 0: the handshake completes and the request is discarded. No queue entry is made.
- Commit: on a rising edge with commit_en && q_count != 0, the head entry is written to its register and popped.
- Simultaneous accept and commit in the same cycle: both take effect. Occupancy is unchanged when the queue was non-empty.
- Accept when empty with commit_en high: the entry is queued. It commits no earlier than the next cycle; there is no same-cycle pass-through.
- Ordering: strictly FIFO. Two queued writes to the same register commit in order, so the later value wins.
- Register file: registers 1..31 reset to 0. regs_flat[31:0] is constant 0.
- Hazard query (combinational):
  - q_pending = 1 if any valid entry has addr == q_addr and q_addr != 0.
  - q_fwd_data = data of the youngest matching entry. It is 0 when there is no match.
- Queue states, encoded by q_count: EMPTY (0), ONE (1), FULL (2).
  - EMPTY to ONE: accept.
  - ONE to FULL: accept without commit.
  - ONE to EMPTY: commit without accept.
  - FULL to ONE: commit without accept.
  - All other combinations hold the current state.

## Timing
- Reset, asynchronous on reset_n low: q_count = 0 and all registers = 0. Outputs become wr_ready = 1, q_pending = 0, q_fwd_data = 0, regs_flat = 0.
- Reset mid-operation: queued entries are dropped with no commit. A request handshaken in the same edge as reset assertion is lost.
- Latency from accept edge to visible on regs_flat: minimum 2 edges (accept, then commit). It grows by one edge per cycle with commit_en low.
- q_pending and q_fwd_data reflect queue contents after the most recent edge. They are combinational in q_addr.
- regs_flat changes only on a commit edge or on reset.
- wr_ready depends combinationally on commit_en. The upstream stage must not make wr_valid depend on wr_ready.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: q_fwd_data behaves as described under Operation.
  - Undefined: q_fwd_data is tied to 0 and the youngest-match logic is removed. q_pending is still produced, so the consumer stalls on a hazard instead of forwarding.

## Test plan
- Reset, then write r5 = 0xDEADBEEF with commit_en = 1 held:
  - wr_ready = 1 throughout.
  - regs_flat[191:160] = 0xDEADBEEF exactly 2 edges after the accept.
  - q_count sequence: 0, 1, 0.
- commit_en = 0, writes r3 = 0x11 then r3 = 0x22, then a third request:
  - q_count = 2 and wr_ready = 0.
  - q_addr = 3 gives q_pending = 1 and q_fwd_data = 0x22 (0 with the macro undefined).
  - The third request is not accepted until commit_en rises.
  - Release commit_en: r3 = 0x11, then r3 = 0x22 on consecutive edges.
- Write r0 = 0xFFFFFFFF with commit_en = 0:
  - Handshake completes and q_count stays 0.
  - regs_flat[31:0] = 0.
  - q_addr = 0 gives q_pending = 0.
- Queue full with commit_en = 1 and wr_valid = 1 on every cycle:
  - wr_ready = 1 every cycle.
  - One accept and one commit per edge; q_count holds at 2.
  - Commits arrive in issue order.
- Two entries queued, then reset_n pulsed low for a half cycle between edges:
  - Immediately q_count = 0, q_pending = 0, and all registers = 0.
  - Neither entry commits after reset releases.

Source files
------------

// File: rtl/regfile_write_port.sv
// regfile_write_port
//
// Write side of the 32 x 32-bit architectural register file. Write-back
// requests arrive over a valid/ready handshake, wait in a 2-entry in-order
// queue, and the head entry commits into the register array on any edge
// where commit_en is high. Register 0 reads as zero and is never stored.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - q_fwd_data returns the youngest queued write to q_addr
//   undefined - q_fwd_data is tied to 0 (consumers stall on q_pending)
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   wr_valid    write request present
//   wr_ready    queue can take a request this cycle (depends on commit_en)
//   wr_addr     destination register of the request
//   wr_data     write data of the request
//   commit_en   allow the head entry to commit this cycle
//   regs_flat   all registers, register r at bits [32r+31:32r]
//   q_addr      hazard query address
//   q_pending   a queued, uncommitted write targets q_addr
//   q_fwd_data  data of the youngest queued write to q_addr (0 if none)
//   q_count     queue occupancy, 0..2

module regfile_write_port #(
    parameter int DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          commit_en,
    output logic [1023:0] regs_flat,
    input  logic [4:0]    q_addr,
    output logic          q_pending,
    output logic [31:0]   q_fwd_data,
    output logic [1:0]    q_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Entry 0 is always the head; entry 1 is only meaningful when FULL.
    logic [4:0]  addr_q [DEPTH];
    logic [4:0]  addr_d [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];

    logic [31:0] regs_q [1:31];

    logic        do_pop;
    logic        do_push;
    logic        push_to_1;
    logic        hit0;
    logic        hit1;
    logic        q_nonzero;

    // Handshake, occupancy state and queue next-state
    always_comb begin
        do_pop   = commit_en && (state_q != EMPTY);
        // A full queue can still accept when the head leaves on the same edge.
        wr_ready = (state_q != FULL) || do_pop;
        // Writes to r0 complete the handshake but never occupy a slot.
        do_push  = wr_valid && wr_ready && (wr_addr != 5'd0);

        state_d = state_q;
        case (state_q)
            EMPTY: if (do_push) state_d = ONE;
            ONE: begin
                if (do_push && !do_pop)      state_d = FULL;
                else if (!do_push && do_pop) state_d = EMPTY;
            end
            FULL:    if (!do_push && do_pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase

        addr_d = addr_q;
        data_d = data_q;
        if (do_pop) begin
            addr_d[0] = addr_q[1];
            data_d[0] = data_q[1];
        end
        // New entry lands just behind whatever survives this edge's pop.
        push_to_1 = (state_q == FULL) || ((state_q == ONE) && !do_pop);
        if (do_push) begin
            if (push_to_1) begin
                addr_d[1] = wr_addr;
                data_d[1] = wr_data;
            end else begin
                addr_d[0] = wr_addr;
                data_d[0] = wr_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload storage needs no reset: slots are qualified by state_q.
    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Architectural registers, written only by a head commit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 1; r < 32; r++) begin
                regs_q[r] <= '0;
            end
        end else if (do_pop) begin
            for (int r = 1; r < 32; r++) begin
                if (addr_q[0] == 5'(r)) begin
                    regs_q[r] <= data_q[0];
                end
            end
        end
    end

    always_comb begin
        regs_flat[31:0] = '0;
        for (int r = 1; r < 32; r++) begin
            regs_flat[32*r +: 32] = regs_q[r];
        end
    end

    assign q_count = state_q;

    // Hazard query against the current queue contents
    always_comb begin
        q_nonzero = (q_addr != 5'd0);
        hit0      = (state_q != EMPTY) && (addr_q[0] == q_addr);
        hit1      = (state_q == FULL)  && (addr_q[1] == q_addr);
        q_pending = q_nonzero && (hit0 || hit1);
`ifdef REGFILE_BYPASS_EN
        // Entry 1 is younger than entry 0, so it takes priority.
        if (!q_nonzero)  q_fwd_data = '0;
        else if (hit1)   q_fwd_data = data_q[1];
        else if (hit0)   q_fwd_data = data_q[0];
        else             q_fwd_data = '0;
`else
        q_fwd_data = '0;
`endif
    end

endmodule
